exu_cal: RTL and testbench

//  Calculation centre: responder end of the ALU->cal val/rdy interface. Receives an

---
 rtl/exu_cal_pkg.sv | 42 ++++
 rtl/exu_cal_shift.sv | 65 ++++++
 rtl/exu_cal.sv | 107 ++++++++++
 tb/tb_exu_cal.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_cal_pkg.sv
// Shared definitions for the calculation centre: operation-bundle layout,
// FSM state and shift-kind encodings.
package exu_cal_pkg;

  localparam int CAL_OP_ADD = 0;
  localparam int CAL_OP_SUB = 1;
  localparam int CAL_OP_SLL = 2;
  localparam int CAL_OP_SRL = 3;
  localparam int CAL_OP_SRA = 4;
  localparam int CAL_OP_XOR = 5;
  localparam int CAL_OP_CMP = 6;

  localparam int CAL_OP_W     = 7;
  localparam int CAL_OPN_W    = 33;
  localparam int CAL_OPB_SIZE = CAL_OP_W + 2 * CAL_OPN_W;

  // Bundle layout, MSB first: OPN1[32:0], OPN2[32:0], op one-hot[6:0].
  typedef struct packed {
    logic [CAL_OPN_W-1:0] opn1;
    logic [CAL_OPN_W-1:0] opn2;
    logic [CAL_OP_W-1:0]  op;
  } cal_opb_t;

  typedef enum logic [1:0] {
    CAL_ST_IDLE  = 2'd0,
    CAL_ST_SHIFT = 2'd1,
    CAL_ST_DONE  = 2'd2
  } cal_state_e;

  typedef enum logic [1:0] {
    CAL_SHK_SLL = 2'd0,
    CAL_SHK_SRL = 2'd1,
    CAL_SHK_SRA = 2'd2
  } cal_shk_e;

  function automatic cal_shk_e shift_kind(input logic [CAL_OP_W-1:0] op);
    if (op[CAL_OP_SRA])      return CAL_SHK_SRA;
    else if (op[CAL_OP_SRL]) return CAL_SHK_SRL;
    else                     return CAL_SHK_SLL;
  endfunction

endpackage

// File: rtl/exu_cal_shift.sv
// Iterative shifter: loads a word and a shift amount, then moves at most
// SHIFT_STEP bit positions per cycle until the remaining count reaches zero.
module cal_shift_iter
  import exu_cal_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  cal_shk_e    kind,
  input  logic [4:0]  amount,
  input  logic [31:0] data,
  input  logic        abort,
  output logic        busy,
  output logic        last,
  output logic [31:0] value
);

  localparam logic [5:0] STEP_W = 6'(SHIFT_STEP);

  cal_shk_e    kind_q;
  logic [31:0] shreg;
  logic [4:0]  cnt;
  logic [4:0]  k;
  logic [31:0] stepped;

  // NOTE: every variable gets a value on every path through always_comb,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    stepped = shreg;
    // When SHIFT_STEP is 32 the first branch is unreachable since cnt <= 31.
    k = ({1'b0, cnt} > STEP_W) ? STEP_W[4:0] : cnt;
    unique case (kind_q)
      CAL_SHK_SLL: stepped = shreg << k;
      CAL_SHK_SRL: stepped = shreg >> k;
      CAL_SHK_SRA: stepped = 32'($signed(shreg) >>> k);
      default:     stepped = shreg;
    endcase
  end

  assign busy  = (cnt != 5'd0);
  assign last  = busy && ({1'b0, cnt} <= STEP_W);
  assign value = shreg;

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      cnt    <= '0;
      kind_q <= CAL_SHK_SLL;
    end else if (abort) begin
      cnt <= '0;
    end else if (load) begin
      shreg  <= data;
      cnt    <= amount;
      kind_q <= kind;
    end else if (busy) begin
      shreg <= stepped;
      cnt   <= cnt - k;
    end
  end

endmodule

// File: rtl/exu_cal.sv
// Calculation centre: single-cycle ADD/SUB/XOR/CMP and multi-cycle shifts
// behind a val/rdy responder interface; rdy stays high whenever idle.
module exu_cal
  import exu_cal_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hs_al4cal_val,
  output logic                    hs_cal4al_rdy,
  input  logic [CAL_OPB_SIZE-1:0] i_cal_opb,
  output logic [31:0]             o_cal_res
);

  cal_opb_t   opb;
  cal_state_e state;

  logic        is_shift;
  logic        sub_like;
  logic [4:0]  sh;
  logic        start_shift;
  logic        abort;
  logic [32:0] b_eff;
  logic [33:0] sum;
  logic [31:0] comb_res;
  logic        shift_busy;
  logic        shift_last;
  logic [31:0] shift_value;

  assign opb      = cal_opb_t'(i_cal_opb);
  assign sh       = opb.opn2[4:0];
  assign is_shift = opb.op[CAL_OP_SLL] | opb.op[CAL_OP_SRL] | opb.op[CAL_OP_SRA];
  assign sub_like = opb.op[CAL_OP_SUB] | opb.op[CAL_OP_CMP];

  assign start_shift = hs_al4cal_val && (state == CAL_ST_IDLE) && is_shift && (sh != 5'd0);
  assign abort       = !hs_al4cal_val && (state != CAL_ST_IDLE);

  // One 34-bit adder serves ADD, SUB and CMP; the extra sign bit makes the
  // 33-bit signed difference exact, so its MSB is the less-than flag.
  assign b_eff = sub_like ? ~opb.opn2 : opb.opn2;
  assign sum   = {opb.opn1[32], opb.opn1} + {b_eff[32], b_eff} + 34'(sub_like);

  always_comb begin
    comb_res = '0;
    if (opb.op[CAL_OP_ADD] || opb.op[CAL_OP_SUB]) comb_res = sum[31:0];
    else if (opb.op[CAL_OP_XOR])                  comb_res = opb.opn1[31:0] ^ opb.opn2[31:0];
    else if (opb.op[CAL_OP_CMP])                  comb_res = {31'd0, sum[33]};
    else if (is_shift)                            comb_res = opb.opn1[31:0];
  end

  cal_shift_iter #(
    .SHIFT_STEP(SHIFT_STEP)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (start_shift),
    .kind  (shift_kind(opb.op)),
    .amount(sh),
    .data  (opb.opn1[31:0]),
    .abort (abort),
    .busy  (shift_busy),
    .last  (shift_last),
    .value (shift_value)
  );

  // Results must appear in the request cycle, so outputs decode state combinationally.
  always_comb begin
    hs_cal4al_rdy = 1'b1;
    o_cal_res     = '0;
    unique case (state)
      CAL_ST_IDLE: begin
        hs_cal4al_rdy = !start_shift;
        o_cal_res     = (hs_al4cal_val && !start_shift) ? comb_res : 32'd0;
      end
      CAL_ST_SHIFT: hs_cal4al_rdy = 1'b0;
      CAL_ST_DONE:  o_cal_res = hs_al4cal_val ? shift_value : 32'd0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CAL_ST_IDLE;
    end else begin
      unique case (state)
        CAL_ST_IDLE:  if (start_shift) state <= CAL_ST_SHIFT;
        CAL_ST_SHIFT: begin
          if (!hs_al4cal_val)  state <= CAL_ST_IDLE;
          else if (shift_last) state <= CAL_ST_DONE;
        end
        CAL_ST_DONE:  state <= CAL_ST_IDLE;
        default:      state <= CAL_ST_IDLE;
      endcase
    end
  end

  a_onehot_op: assert property (@(posedge clk) disable iff (rst)
    hs_al4cal_val |-> $onehot0(opb.op));

  a_opb_stable: assert property (@(posedge clk) disable iff (rst)
    (hs_al4cal_val && !hs_cal4al_rdy) |=> (!hs_al4cal_val || $stable(i_cal_opb)));

  a_shift_busy: assert property (@(posedge clk) disable iff (rst)
    (state == CAL_ST_SHIFT) |-> shift_busy);

endmodule

// File: tb/tb_exu_cal.sv
// Self-checking bench for exu_cal: directed corner cases plus randomized
// requests compared against an arithmetic reference model.
module tb_exu_cal;
  import exu_cal_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    val, val32;
  logic                    rdy, rdy32;
  logic [CAL_OPB_SIZE-1:0] opb;
  logic [31:0]             res, res32;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exu_cal #(.SHIFT_STEP(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .hs_al4cal_val(val),
    .hs_cal4al_rdy(rdy),
    .i_cal_opb    (opb),
    .o_cal_res    (res)
  );

  exu_cal #(.SHIFT_STEP(32)) dut32 (
    .clk          (clk),
    .rst          (rst),
    .hs_al4cal_val(val32),
    .hs_cal4al_rdy(rdy32),
    .i_cal_opb    (opb),
    .o_cal_res    (res32)
  );

  function automatic logic [CAL_OPB_SIZE-1:0] make_opb(input int op, input logic [32:0] a,
                                                       input logic [32:0] b);
    cal_opb_t s;
    s.opn1  = a;
    s.opn2  = b;
    s.op    = '0;
    s.op[op] = 1'b1;
    return s;
  endfunction

  function automatic bit is_shift_op(input int op);
    return op == CAL_OP_SLL || op == CAL_OP_SRL || op == CAL_OP_SRA;
  endfunction

  function automatic logic [31:0] ref_res(input int op, input logic [32:0] a, input logic [32:0] b);
    logic [31:0]        a32 = a[31:0];
    logic [31:0]        b32 = b[31:0];
    logic signed [31:0] sa  = a[31:0];
    logic signed [32:0] a33 = a;
    logic signed [32:0] b33 = b;
    int                 sh  = int'(b[4:0]);
    case (op)
      CAL_OP_ADD: return a32 + b32;
      CAL_OP_SUB: return a32 - b32;
      CAL_OP_XOR: return a32 ^ b32;
      CAL_OP_CMP: return (a33 < b33) ? 32'd1 : 32'd0;
      CAL_OP_SLL: return a32 << sh;
      CAL_OP_SRL: return a32 >> sh;
      CAL_OP_SRA: return sa >>> sh;
      default:    return 32'd0;
    endcase
  endfunction

  // Cycle index (0 = first val cycle) at which rdy is expected.
  function automatic int ref_lat(input int op, input logic [32:0] b, input int step);
    int sh = int'(b[4:0]);
    if (!is_shift_op(op) || sh == 0) return 0;
    return (sh + step - 1) / step + 1;
  endfunction

  task automatic run_req(input string name, input int op, input logic [32:0] a,
                         input logic [32:0] b, input bit use32 = 1'b0);
    int          lat = ref_lat(op, b, use32 ? 32 : 4);
    logic [31:0] exp = ref_res(op, a, b);
    logic        got_rdy;
    logic [31:0] got_res;
    @(posedge clk);
    #1;
    opb   = make_opb(op, a, b);
    val   = !use32;
    val32 = use32;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      got_rdy = use32 ? rdy32 : rdy;
      got_res = use32 ? res32 : res;
      checks++;
      if (c < lat) begin
        if (got_rdy !== 1'b0 || got_res !== 32'd0) begin
          failures++;
          $display("FAIL %s cycle %0d: rdy=%b res=%h, required rdy=0 res=0", name, c, got_rdy, got_res);
        end
      end else if (got_rdy !== 1'b1 || got_res !== exp) begin
        failures++;
        $display("FAIL %s cycle %0d: rdy=%b res=%h, required rdy=1 res=%h", name, c, got_rdy, got_res, exp);
      end
    end
  endtask

  task automatic expect_out(input string name, input logic e_rdy, input logic [31:0] e_res);
    checks++;
    if (rdy !== e_rdy || res !== e_res) begin
      failures++;
      $display("FAIL %s: rdy=%b res=%h, required rdy=%b res=%h", name, rdy, res, e_rdy, e_res);
    end
  endtask

  task automatic idle_cycles(input int n);
    @(posedge clk);
    #1;
    val   = 1'b0;
    val32 = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      expect_out("idle", 1'b1, 32'd0);
      checks++;
      if (rdy32 !== 1'b1 || res32 !== 32'd0) begin
        failures++;
        $display("FAIL idle32: rdy=%b res=%h, required rdy=1 res=0", rdy32, res32);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    expect_out("reset", 1'b1, 32'd0);
  endtask

  task automatic test_arith();
    run_req("add_wrap", CAL_OP_ADD, 33'h0_FFFF_FFFF, 33'd1);
    run_req("sub_wrap", CAL_OP_SUB, 33'd0, 33'd1);
    run_req("cmp_signed", CAL_OP_CMP, 33'h1_FFFF_FFFF, 33'd1);
    run_req("cmp_unsigned", CAL_OP_CMP, 33'h0_FFFF_FFFF, 33'd1);
    run_req("xor", CAL_OP_XOR, 33'h0_A5A5_F00F, 33'h1_0FF0_FFFF);
  endtask

  task automatic test_shift();
    run_req("sll_5", CAL_OP_SLL, 33'd1, 33'd5);
    run_req("sra_31", CAL_OP_SRA, 33'h0_8000_0000, 33'd31);
    run_req("srl_0", CAL_OP_SRL, 33'h0_0000_1234, 33'h1_FFFF_FFE0);
    run_req("srl_31_step32", CAL_OP_SRL, 33'h0_DEAD_BEEF, 33'd31, 1'b1);
    run_req("sll_1_step32", CAL_OP_SLL, 33'h0_0000_0003, 33'd1, 1'b1);
    run_req("sll_4_exact", CAL_OP_SLL, 33'h0_0000_00F1, 33'd4);
  endtask

  task automatic test_abort();
    @(posedge clk);
    #1;
    val = 1'b1;
    opb = make_opb(CAL_OP_SLL, 33'h0_1234_5678, 33'd20);
    @(negedge clk);
    expect_out("abort_shift_c0", 1'b0, 32'd0);
    @(negedge clk);
    expect_out("abort_shift_c1", 1'b0, 32'd0);
    @(posedge clk);
    #1;
    val = 1'b0;
    @(negedge clk);
    expect_out("abort_shift_c2", 1'b0, 32'd0);
    @(negedge clk);
    expect_out("abort_shift_c3", 1'b1, 32'd0);
    run_req("add_after_abort", CAL_OP_ADD, 33'h0_0000_0010, 33'h0_0000_0022);
    // Drop val exactly in the completion cycle: rdy stays high but no result.
    @(posedge clk);
    #1;
    opb = make_opb(CAL_OP_SRL, 33'h0_F000_0000, 33'd4);
    @(negedge clk);
    expect_out("abort_done_c0", 1'b0, 32'd0);
    @(negedge clk);
    expect_out("abort_done_c1", 1'b0, 32'd0);
    @(posedge clk);
    #1;
    val = 1'b0;
    @(negedge clk);
    expect_out("abort_done_c2", 1'b1, 32'd0);
    @(negedge clk);
    expect_out("abort_done_c3", 1'b1, 32'd0);
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    val = 1'b1;
    opb = make_opb(CAL_OP_SRA, 33'h0_8000_0000, 33'd31);
    @(negedge clk);
    @(negedge clk);
    expect_out("rst_mid_busy", 1'b0, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    val = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    expect_out("rst_mid_after", 1'b1, 32'd0);
    run_req("xor_after_rst", CAL_OP_XOR, 33'h0_FFFF_0000, 33'h0_0F0F_0F0F);
  endtask

  task automatic test_back_to_back();
    run_req("b2b_srl", CAL_OP_SRL, 33'h0_8765_4321, 33'd9);
    run_req("b2b_xor", CAL_OP_XOR, 33'h0_1111_2222, 33'h0_3333_4444);
    run_req("b2b_sll", CAL_OP_SLL, 33'h0_0000_0001, 33'd31);
    run_req("b2b_sra", CAL_OP_SRA, 33'h0_C000_0001, 33'd3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      int          op = int'($urandom_range(0, 6));
      logic [32:0] a  = {1'($urandom), $urandom};
      logic [32:0] b  = {1'($urandom), $urandom};
      if ($urandom_range(0, 5) == 0) b[4:0] = 5'd0;
      run_req("random", op, a, b, $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) idle_cycles(1);
    end
  endtask

  initial begin
    rst   = 1'b1;
    val   = 1'b0;
    val32 = 1'b0;
    opb   = '0;
    test_reset();
    idle_cycles(2);
    test_arith();
    test_shift();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    idle_cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
